// File: rtl/int_mode_ctrl_if.sv
// Bus between the execution-mode controller and the rest of the core.
// The core side is the master (drives requests and pipeline status); the controller is the slave.
interface int_mode_ctrl_if #(
  parameter int NUM_IRQ = 4,
  parameter int PC_W    = 16
);
  logic               start;
  logic [NUM_IRQ-1:0] irq;
  logic               mask_we;
  logic [NUM_IRQ-1:0] mask_din;
  logic [PC_W-1:0]    pc_in;
  logic               pipe_idle;
  logic               reti;
  logic [1:0]         mode;
  logic               stall;
  logic               flush;
  logic               pc_load;
  logic [PC_W-1:0]    pc_target;
  logic [PC_W-1:0]    epc;
  logic [NUM_IRQ-1:0] irq_ack;

  // Single-cycle pulses (flush, pc_load, irq_ack) are events, not levels: each
  // high cycle is one redirect/ack; stall holds until pipe_idle is seen.
  modport master (
    output start, irq, mask_we, mask_din, pc_in, pipe_idle, reti,
    input  mode, stall, flush, pc_load, pc_target, epc, irq_ack
  );
  modport slave (
    input  start, irq, mask_we, mask_din, pc_in, pipe_idle, reti,
    output mode, stall, flush, pc_load, pc_target, epc, irq_ack
  );
endinterface

// File: rtl/int_mode_ctrl.sv
// Execution-mode sequencer: boot -> user -> interrupt handler -> user, with
// edge-latched, fixed-priority interrupt requests and fetch redirect on entry/return.
module int_mode_ctrl #(
  parameter int              NUM_IRQ    = 4,
  parameter int              PC_W       = 16,
  parameter logic [PC_W-1:0] VEC_BASE   = 16'hFF00,
  parameter int              VEC_STRIDE = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  int_mode_ctrl_if.slave   bus,
  output logic [2:0]       o_dbg_state
);
  localparam int CUR_W = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_USER    = 3'd1,
    S_DRAIN   = 3'd2,
    S_HANDLER = 3'd3,
    S_RESUME  = 3'd4
  } state_t;

  state_t             r_state;
  logic [1:0]         r_mode;
  logic               r_stall;
  logic               r_flush;
  logic               r_pc_load;
  logic [PC_W-1:0]    r_pc_target;
  logic [PC_W-1:0]    r_epc;
  logic [NUM_IRQ-1:0] r_irq_ack;
  logic [NUM_IRQ-1:0] r_irq_q;
  logic [NUM_IRQ-1:0] r_pending;
  logic [NUM_IRQ-1:0] r_enable;
  logic [CUR_W-1:0]   r_cur;

  logic [NUM_IRQ-1:0] w_hit;
  logic               w_any;
  logic [CUR_W-1:0]   w_win;
  logic [PC_W-1:0]    w_vec;

  // Descending scan so the lowest active index is the last write and wins.
  always_comb begin
    w_hit = r_pending & r_enable;
    w_any = |w_hit;
    w_win = '0;
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (w_hit[i]) w_win = CUR_W'(i);
    end
  end

  assign w_vec = VEC_BASE + PC_W'(VEC_STRIDE) * PC_W'(r_cur);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_mode      <= 2'b00;
      r_stall     <= 1'b0;
      r_flush     <= 1'b0;
      r_pc_load   <= 1'b0;
      r_pc_target <= '0;
      r_epc       <= '0;
      r_irq_ack   <= '0;
      r_irq_q     <= '0;
      r_pending   <= '0;
      r_enable    <= '0;
      r_cur       <= '0;
    end else begin
      r_irq_q   <= bus.irq;
      // A fresh edge in the ack cycle must not be lost, so set wins over clear.
      r_pending <= (r_pending & ~r_irq_ack) | (bus.irq & ~r_irq_q);
      if (bus.mask_we) r_enable <= bus.mask_din;
      r_flush   <= 1'b0;
      r_pc_load <= 1'b0;
      r_irq_ack <= '0;

      case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            r_state <= S_USER;
            r_mode  <= 2'b01;
          end
        end
        S_USER: begin
          if (w_any) begin
            r_state <= S_DRAIN;
            r_stall <= 1'b1;
            r_cur   <= w_win;
          end
        end
        S_DRAIN: begin
          if (bus.pipe_idle) begin
            r_state     <= S_HANDLER;
            r_mode      <= 2'b10;
            r_stall     <= 1'b0;
            r_epc       <= bus.pc_in;
            r_pc_load   <= 1'b1;
            r_flush     <= 1'b1;
            r_pc_target <= w_vec;
            r_irq_ack   <= NUM_IRQ'(1) << r_cur;
          end
        end
        S_HANDLER: begin
          if (bus.reti) begin
            r_state     <= S_RESUME;
            r_pc_load   <= 1'b1;
            r_flush     <= 1'b1;
            r_pc_target <= r_epc;
          end
        end
        S_RESUME: begin
          r_state <= S_USER;
          r_mode  <= 2'b01;
        end
        default: begin
          r_state <= S_IDLE;
          r_mode  <= 2'b00;
          r_stall <= 1'b0;
        end
      endcase
    end
  end

  assign bus.mode      = r_mode;
  assign bus.stall     = r_stall;
  assign bus.flush     = r_flush;
  assign bus.pc_load   = r_pc_load;
  assign bus.pc_target = r_pc_target;
  assign bus.epc       = r_epc;
  assign bus.irq_ack   = r_irq_ack;
  assign o_dbg_state   = r_state;
endmodule

// File: tb/tb_int_mode_ctrl.sv
// Bench for int_mode_ctrl: directed stimulus, redirect events checked against a queue of
// hand-computed {mode, flush, irq_ack, pc_target, epc} tuples.
module tb_int_mode_ctrl;
  localparam int W = 39;

  logic       clk;
  logic       rst_n;
  logic [2:0] dbg_state;
  int         total;
  int         bad;
  logic [W-1:0] exp_q[$];

  int_mode_ctrl_if #(.NUM_IRQ(4), .PC_W(16)) bus ();

  int_mode_ctrl #(
    .NUM_IRQ(4), .PC_W(16), .VEC_BASE(16'hFF00), .VEC_STRIDE(4)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus),
    .o_dbg_state(dbg_state)
  );

  // ---- clock ----
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [W-1:0] pack(input logic [1:0] m, input logic f,
                                        input logic [3:0] ack, input logic [15:0] tgt,
                                        input logic [15:0] epc);
    return {m, f, ack, tgt, epc};
  endfunction

  // ---- scoreboard monitor: every redirect pulse pops one expectation ----
  always @(negedge clk) begin
    if (bus.pc_load) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL redirect_unexpected act=%h req=none",
                 pack(bus.mode, bus.flush, bus.irq_ack, bus.pc_target, bus.epc));
      end else begin
        logic [W-1:0] e;
        logic [W-1:0] a;
        e = exp_q.pop_front();
        a = pack(bus.mode, bus.flush, bus.irq_ack, bus.pc_target, bus.epc);
        if (a !== e) begin
          bad++;
          $display("FAIL redirect act=%h req=%h", a, e);
        end
      end
    end
  end

  // ---- driver tasks ----
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s act=%0h req=%0h", name, act, req);
    end
  endtask

  task automatic set_mask(input logic [3:0] m);
    bus.mask_we  = 1'b1;
    bus.mask_din = m;
    tick();
    bus.mask_we  = 1'b0;
  endtask

  task automatic pulse_irq(input logic [3:0] b);
    bus.irq = b;
    tick();
    bus.irq = 4'b0000;
  endtask

  task automatic wait_stall(input string name);
    int n;
    n = 0;
    while (bus.stall !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    check(name, 64'(bus.stall), 64'(1'b1));
  endtask

  task automatic service(input logic [15:0] pc, input logic [3:0] ack,
                         input logic [15:0] vec, input string name);
    check({name, "_drain_mode"}, 64'(bus.mode), 64'(2'b01));
    bus.pc_in = pc;
    exp_q.push_back(pack(2'b10, 1'b1, ack, vec, pc));
    bus.pipe_idle = 1'b1;
    tick();
    bus.pipe_idle = 1'b0;
    check({name, "_handler_mode"}, 64'(bus.mode), 64'(2'b10));
  endtask

  task automatic do_reti(input logic [15:0] epc, input string name);
    exp_q.push_back(pack(2'b10, 1'b1, 4'b0000, epc, epc));
    bus.reti = 1'b1;
    tick();
    bus.reti = 1'b0;
    check({name, "_resume_mode"}, 64'(bus.mode), 64'(2'b10));
    tick();
    check({name, "_user_mode"}, 64'(bus.mode), 64'(2'b01));
    check({name, "_user_stall"}, 64'(bus.stall), 64'(1'b0));
  endtask

  // ---- stimulus ----
  initial begin
    total = 0;
    bad   = 0;
    rst_n = 1'b0;
    bus.start = 1'b0; bus.irq = '0; bus.mask_we = 1'b0; bus.mask_din = '0;
    bus.pc_in = '0; bus.pipe_idle = 1'b0; bus.reti = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;

    // 1: reset state and boot
    check("rst_mode", 64'(bus.mode), 64'(2'b00));
    check("rst_stall", 64'(bus.stall), 64'(1'b0));
    check("rst_epc", 64'(bus.epc), 64'(16'h0000));
    check("rst_ack", 64'(bus.irq_ack), 64'(4'b0000));
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    check("boot_mode", 64'(bus.mode), 64'(2'b01));

    // 2: single irq 2
    set_mask(4'b1111);
    pulse_irq(4'b0100);
    wait_stall("t2_stall");
    service(16'h0123, 4'b0100, 16'hFF08, "t2");
    do_reti(16'h0123, "t2");

    // 3: simultaneous 3 and 1 -> 1 first, 3 after one user cycle
    pulse_irq(4'b1010);
    wait_stall("t3a_stall");
    service(16'h0200, 4'b0010, 16'hFF04, "t3a");
    do_reti(16'h0200, "t3a");
    tick();
    check("t3b_stall", 64'(bus.stall), 64'(1'b1));
    service(16'h0300, 4'b1000, 16'hFF0C, "t3b");
    do_reti(16'h0300, "t3b");

    // 4: masked source held pending until enabled
    set_mask(4'b1110);
    pulse_irq(4'b0001);
    for (int i = 0; i < 4; i++) begin
      tick();
      check("t4_masked_stall", 64'(bus.stall), 64'(1'b0));
    end
    set_mask(4'b1111);
    wait_stall("t4_stall");
    service(16'h0400, 4'b0001, 16'hFF00, "t4");
    do_reti(16'h0400, "t4");

    // 5: no nesting; irq raised in handler is taken after return
    pulse_irq(4'b0100);
    wait_stall("t5a_stall");
    service(16'h0500, 4'b0100, 16'hFF08, "t5a");
    pulse_irq(4'b0010);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("t5_nonest_mode", 64'(bus.mode), 64'(2'b10));
    end
    do_reti(16'h0500, "t5a");
    wait_stall("t5b_stall");
    service(16'h0600, 4'b0010, 16'hFF04, "t5b");
    do_reti(16'h0600, "t5b");

    // 6: reset in the middle of DRAIN
    pulse_irq(4'b0001);
    wait_stall("t6_stall");
    check("t6_state_drain", 64'(dbg_state), 64'(3'd2));
    rst_n = 1'b0;
    tick();
    check("t6_mode", 64'(bus.mode), 64'(2'b00));
    check("t6_stall0", 64'(bus.stall), 64'(1'b0));
    check("t6_ack", 64'(bus.irq_ack), 64'(4'b0000));
    check("t6_state_idle", 64'(dbg_state), 64'(3'd0));
    rst_n = 1'b1;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    set_mask(4'b1111);
    for (int i = 0; i < 4; i++) begin
      tick();
      check("t6_no_pending", 64'(bus.stall), 64'(1'b0));
    end

    tick();
    tick();
    check("queue_drained", 64'(exp_q.size()), 64'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
